// File: rtl/display_spi_tx.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// display_spi_tx
//
// Buffered SPI transmitter for SSD1306-class OLED panels. Command bytes, data
// bytes and panel-reset requests are queued in a FIFO through a valid/ready
// port, then replayed in order on the panel pins. The serial format is SPI
// mode 0, MSB first. SCK rate and the width of the reset pulse are
// parameters.
//
// Optional feature (macro DISPLAY_SPI_BURST_EN):
//   When defined, consecutive byte entries with the same D/C value share one
//   chip-select window. When undefined, CS is released after every byte.
//
// Parameters
//   CLK_DIV       clk cycles per SCK half-period (>= 1)
//   FIFO_DEPTH    FIFO entries (power of two, >= 2)
//   RESET_CYCLES  spi_rst low time, and the recovery time after release
//
// Ports
//   clk, rst          system clock, asynchronous active-high reset
//   in_valid/ready    entry handshake; in_ready = FIFO not full
//   in_reset          entry is a panel-reset request (in_dc/in_byte ignored)
//   in_dc, in_byte    D/C flag (0 = command) and payload
//   busy              FIFO non-empty or engine active
//   fifo_level        number of stored entries
//   spi_din/clk/dc    serial data, SCK, data/command select
//   spi_cs, spi_rst   chip select and panel reset, both active-low
// -----------------------------------------------------------------------------
module display_spi_tx #(
    parameter int CLK_DIV      = 11,
    parameter int FIFO_DEPTH   = 16,
    parameter int RESET_CYCLES = 1000
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic                              in_reset,
    input  logic                              in_dc,
    input  logic [7:0]                        in_byte,
    output logic                              busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
    output logic                              spi_din,
    output logic                              spi_clk,
    output logic                              spi_cs,
    output logic                              spi_dc,
    output logic                              spi_rst
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int RW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);
    localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
    localparam logic [RW-1:0] RST_LAST   = RW'(RESET_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST_LOW,
        S_RST_WAIT,
        S_LOAD,
        S_SHIFT,
        S_END,
        S_GAP
    } state_e;

    // ---------------------------------------------------------------- FIFO
    // Entry layout: {reset, dc, byte[7:0]}
    logic [9:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [LW-1:0] level_q;
    logic [LW-1:0] level_d;
    logic [9:0]    head;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic          cont;

    state_e        state_q;
    logic [DW-1:0] div_q;
    logic [RW-1:0] rcnt_q;
    logic [3:0]    bit_cnt_q;
    logic [7:0]    sh_q;
    logic          cur_dc_q;
    logic          spi_din_q;
    logic          spi_clk_q;
    logic          spi_cs_q;
    logic          spi_dc_q;
    logic          spi_rst_q;

    assign head       = mem_q[rd_ptr_q];
    assign fifo_empty = (level_q == '0);
    assign in_ready   = (level_q != LEVEL_FULL);
    assign push       = in_valid && in_ready;

    // NOTE: the storage array has no reset; only the pointers and level
    // define which entries are valid, so clearing the array buys nothing.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_reset, in_dc, in_byte};
        end
    end

    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path through the block leaves it holding a latched value.
    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, independent of order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            level_q <= level_d;
        end
    end

    // ------------------------------------------------------ burst decision
`ifdef DISPLAY_SPI_BURST_EN
    // Keep CS low only for a byte entry whose D/C matches the byte on the wire.
    assign cont = !fifo_empty && !head[9] && (head[8] == spi_dc_q);
`else
    assign cont = 1'b0;
`endif

    always_comb begin
        pop = 1'b0;
        if (state_q == S_IDLE && !fifo_empty) pop = 1'b1;
        if (state_q == S_END && cont)         pop = 1'b1;
    end

    // --------------------------------------------------------------- engine
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            rcnt_q    <= '0;
            bit_cnt_q <= '0;
            sh_q      <= '0;
            cur_dc_q  <= 1'b0;
            spi_din_q <= 1'b0;
            spi_clk_q <= 1'b0;
            spi_cs_q  <= 1'b1;
            spi_dc_q  <= 1'b0;
            spi_rst_q <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        if (head[9]) begin
                            spi_rst_q <= 1'b0;
                            rcnt_q    <= '0;
                            state_q   <= S_RST_LOW;
                        end else begin
                            cur_dc_q <= head[8];
                            sh_q     <= head[7:0];
                            state_q  <= S_LOAD;
                        end
                    end
                end
                S_RST_LOW: begin
                    if (rcnt_q == RST_LAST) begin
                        spi_rst_q <= 1'b1;
                        rcnt_q    <= '0;
                        state_q   <= S_RST_WAIT;
                    end else begin
                        rcnt_q <= rcnt_q + RW'(1);
                    end
                end
                S_RST_WAIT: begin
                    if (rcnt_q == RST_LAST) begin
                        rcnt_q  <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        rcnt_q <= rcnt_q + RW'(1);
                    end
                end
                S_LOAD: begin
                    spi_cs_q  <= 1'b0;
                    spi_dc_q  <= cur_dc_q;
                    spi_din_q <= sh_q[7];
                    sh_q      <= {sh_q[6:0], 1'b0};
                    bit_cnt_q <= 4'd8;
                    div_q     <= '0;
                    state_q   <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (div_q == DIV_LAST) begin
                        div_q     <= '0;
                        spi_clk_q <= ~spi_clk_q;
                        // SCK currently high: this toggle is a falling edge,
                        // the only point where din may change.
                        if (spi_clk_q) begin
                            bit_cnt_q <= bit_cnt_q - 4'd1;
                            if (bit_cnt_q != 4'd1) begin
                                spi_din_q <= sh_q[7];
                                sh_q      <= {sh_q[6:0], 1'b0};
                            end else begin
                                state_q <= S_END;
                            end
                        end
                    end else begin
                        div_q <= div_q + DW'(1);
                    end
                end
                S_END: begin
                    if (cont) begin
                        cur_dc_q <= head[8];
                        sh_q     <= head[7:0];
                        state_q  <= S_LOAD;
                    end else begin
                        spi_cs_q <= 1'b1;
                        div_q    <= '0;
                        state_q  <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (div_q == DIV_LAST) begin
                        div_q   <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        div_q <= div_q + DW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy       = !fifo_empty || (state_q != S_IDLE);
    assign fifo_level = level_q;
    assign spi_din    = spi_din_q;
    assign spi_clk    = spi_clk_q;
    assign spi_cs     = spi_cs_q;
    assign spi_dc     = spi_dc_q;
    assign spi_rst    = spi_rst_q;

endmodule
